if_fetch: RTL

Instruction-fetch stage directly downstream of the PC register. Each cycle it samples the PC and its chip-enable, fetches one instruction over a request/grant/response memory handshake, and presents the PC and instruction pair in the IF/ID register to the decode stage. It honours stall and flush from downstream. It raises a hold signal so the PC source does not advance while a fetch is outstanding or the output slot is blocked.

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/if_resp_buf.sv | 32 +++
 rtl/if_fetch.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and
// fetch-related constants.
package if_fetch_pkg;

    typedef enum logic [2:0] {
        IF_IDLE = 3'd0,
        IF_REQ  = 3'd1,
        IF_WAIT = 3'd2,
        IF_DROP = 3'd3,
        IF_HOLD = 3'd4
    } if_state_e;

    localparam logic [31:0] NOP_INST     = 32'h00000013;
    localparam logic [31:0] ZERO_WORD    = 32'h00000000;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;

    function automatic logic word_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_resp_buf.sv
// One-entry pending buffer holding a fetch response while the IF/ID slot is stalled.
module if_resp_buf #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [INST_W-1:0] load_data,
    output logic              valid,
    output logic [ADDR_W-1:0] buf_pc,
    output logic [INST_W-1:0] buf_data
);

    // Clear wins over load so a flush can never leave a stale entry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            buf_pc   <= '0;
            buf_data <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            buf_pc   <= load_pc;
            buf_data <= load_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC capture, req/gnt/rvalid fetch, IF/ID register.
// Optional misaligned-PC marker enabled by defining IF_MISALIGN_CHK_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    output logic              pc_hold_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    input  logic              id_stall_i,
    input  logic              flush_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
`ifdef IF_MISALIGN_CHK_EN
    output logic              misalign_o,
`endif
    output logic [2:0]        state_dbg
);

    // Handshakes: a request transfers on a cycle with mem_req_o && mem_gnt_i;
    // a response transfers on any cycle with mem_rvalid_i (never back-pressured);
    // IF/ID transfers to decode on any cycle with id_valid_o && !id_stall_i.

    if_state_e         state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              slot_free, misalign_pc;
    logic              capture, id_load_mem, id_load_buf, id_load_nop, id_clear;
    logic              buf_load, buf_clear, buf_valid;
    logic [ADDR_W-1:0] buf_pc;
    logic [INST_W-1:0] buf_data;

`ifdef IF_MISALIGN_CHK_EN
    assign misalign_pc = word_misaligned(pc_i[1:0]);
`else
    assign misalign_pc = 1'b0;
`endif

    assign slot_free  = !id_valid_o || !id_stall_i;
    assign mem_req_o  = (state == IF_REQ);
    assign mem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
    assign pc_hold_o  = (state != IF_IDLE) || (id_valid_o && id_stall_i);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IF_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        id_load_mem = 1'b0;
        id_load_buf = 1'b0;
        id_load_nop = 1'b0;
        id_clear    = 1'b0;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        if (flush_i) begin
            id_clear  = 1'b1;
            buf_clear = 1'b1;
            case (state)
                IF_REQ:  state_nxt = mem_gnt_i ? IF_DROP : IF_IDLE;
                IF_WAIT: state_nxt = mem_rvalid_i ? IF_IDLE : IF_DROP;
                // The outstanding response is still consumed so DROP cannot wedge.
                IF_DROP: state_nxt = mem_rvalid_i ? IF_IDLE : IF_DROP;
                default: state_nxt = IF_IDLE;
            endcase
        end else begin
            case (state)
                IF_IDLE: begin
                    if (ce_i == CHIP_ENABLE && slot_free) begin
                        if (misalign_pc) begin
                            id_load_nop = 1'b1;
                        end else begin
                            capture   = 1'b1;
                            state_nxt = IF_REQ;
                        end
                    end else if (slot_free) begin
                        id_clear = 1'b1;
                    end
                end
                IF_REQ: if (mem_gnt_i) state_nxt = IF_WAIT;
                IF_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (slot_free) begin
                            id_load_mem = 1'b1;
                            state_nxt   = IF_IDLE;
                        end else begin
                            buf_load  = 1'b1;
                            state_nxt = IF_HOLD;
                        end
                    end
                end
                IF_HOLD: begin
                    if (slot_free && buf_valid) begin
                        id_load_buf = 1'b1;
                        buf_clear   = 1'b1;
                        state_nxt   = IF_IDLE;
                    end
                end
                IF_DROP: if (mem_rvalid_i) state_nxt = IF_IDLE;
                default: state_nxt = IF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       addr_q <= '0;
        else if (capture) addr_q <= pc_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_o <= 1'b0;
            id_pc_o    <= '0;
            id_inst_o  <= '0;
        end else if (id_clear) begin
            id_valid_o <= 1'b0;
        end else if (id_load_mem) begin
            id_valid_o <= 1'b1;
            id_pc_o    <= addr_q;
            id_inst_o  <= mem_rdata_i;
        end else if (id_load_buf) begin
            id_valid_o <= 1'b1;
            id_pc_o    <= buf_pc;
            id_inst_o  <= buf_data;
        end else if (id_load_nop) begin
            id_valid_o <= 1'b1;
            id_pc_o    <= pc_i;
            id_inst_o  <= INST_W'(NOP_INST);
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          misalign_o <= 1'b0;
        else if (id_clear)                   misalign_o <= 1'b0;
        else if (id_load_mem || id_load_buf) misalign_o <= 1'b0;
        else if (id_load_nop)                misalign_o <= 1'b1;
    end
`endif

    if_resp_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_resp_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_pc   (addr_q),
        .load_data (mem_rdata_i),
        .valid     (buf_valid),
        .buf_pc    (buf_pc),
        .buf_data  (buf_data)
    );

endmodule
